// File: rtl/atm_pkg.sv
// Shared encodings for the balance ledger: opcodes, response status and FSM states.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_QUERY    = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK           = 2'b00,
    ST_INSUFFICIENT = 2'b01,
    ST_OVERFLOW     = 2'b10,
    ST_BAD_OP       = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; priority moves to the other requester only when a grant is taken.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio = 1 means requester 1 wins a tie
  logic prio;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          prio <= 1'b0;
    else if (advance) prio <= gnt[0];
  end

endmodule

// File: rtl/balance_ledger_arbiter.sv
// Two-requester balance ledger: arbitrate, latch one transaction, execute it, pulse a response.
module balance_ledger_arbiter
  import atm_pkg::*;
#(
  parameter logic [7:0] INIT_BALANCE = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_amount,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [7:0]  rsp_balance,
  output logic [7:0]  balance,
  output logic        busy
);

  state_e     state, state_nxt;
  logic [1:0] gnt;
  logic       accept;
  logic       grant_q;
  op_e        op_q;
  logic [7:0] amt_q;
  status_e    res_status;
  logic [7:0] res_balance;
  logic [8:0] sum;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign accept = |req_ready;
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      S_IDLE: begin
        if (!rst) req_ready = gnt & req_valid;
        if (|req_ready) state_nxt = S_EXEC;
      end
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result of the latched transaction against the committed balance
  assign sum = {1'b0, balance} + {1'b0, amt_q};

  always_comb begin
    res_status  = ST_OK;
    res_balance = balance;
    case (op_q)
      OP_QUERY: ;
      OP_DEPOSIT: begin
        if (sum[8]) res_status  = ST_OVERFLOW;
        else        res_balance = sum[7:0];
      end
      OP_WITHDRAW: begin
        if (amt_q > balance) res_status  = ST_INSUFFICIENT;
        else                 res_balance = balance - amt_q;
      end
      default: res_status = ST_BAD_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      balance     <= INIT_BALANCE;
      rsp_valid   <= 2'b00;
      rsp_status  <= ST_OK;
      rsp_balance <= 8'd0;
      grant_q     <= 1'b0;
      op_q        <= OP_QUERY;
      amt_q       <= 8'd0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 2'b00;
      if (accept) begin
        grant_q <= req_ready[1];
        op_q    <= op_e'(req_ready[1] ? req_op[3:2] : req_op[1:0]);
        amt_q   <= req_ready[1] ? req_amount[15:8] : req_amount[7:0];
      end
      if (state == S_EXEC) begin
        balance     <= res_balance;
        rsp_status  <= res_status;
        rsp_balance <= res_balance;
        rsp_valid   <= grant_q ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_balance_ledger_arbiter.sv
// Directed bench for balance_ledger_arbiter with INIT_BALANCE = 50.
module tb_balance_ledger_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [15:0] req_amount;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_balance;
  logic [7:0]  balance;
  logic        busy;

  int checks = 0;
  int errors = 0;

  balance_ledger_arbiter #(.INIT_BALANCE(8'd50)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_balance (rsp_balance),
    .balance     (balance),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge. Optionally alters the amount while in EXEC.
  task automatic txn(input string tag, input int r, input logic [1:0] op, input logic [7:0] amt,
                     input logic [1:0] est, input logic [7:0] ebal, input bit tamper);
    bit got = 0;
    logic [1:0] onehot;
    onehot = (r == 1) ? 2'b10 : 2'b01;
    req_op[2*r +: 2]     = op;
    req_amount[8*r +: 8] = amt;
    req_valid[r]         = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[r]) begin got = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_ready"}, {31'd0, got}, 32'd1);
    if (!got) begin req_valid[r] = 1'b0; return; end
    chk({tag, "_ready_onehot"}, {30'd0, req_ready}, {30'd0, onehot});
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    chk({tag, "_exec_rspv"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    if (tamper) req_amount[8*r +: 8] = 8'd200;
    @(negedge clk);
    chk({tag, "_rspv"},    {30'd0, rsp_valid},   {30'd0, onehot});
    chk({tag, "_status"},  {30'd0, rsp_status},  {30'd0, est});
    chk({tag, "_rspbal"},  {24'd0, rsp_balance}, {24'd0, ebal});
    chk({tag, "_balance"}, {24'd0, balance},     {24'd0, ebal});
    @(negedge clk);
    chk({tag, "_idle_rspv"},   {30'd0, rsp_valid},  32'd0);
    chk({tag, "_hold_status"}, {30'd0, rsp_status}, {30'd0, est});
    chk({tag, "_idle_busy"},   {31'd0, busy},       32'd0);
  endtask

  initial begin
    int grants[5];
    int gcyc[5];
    int ng;
    bit both_ready;
    bit saw_rsp;

    rst = 1'b1; req_valid = 2'b11; req_op = '0; req_amount = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_balance", {24'd0, balance},     32'd50);
    chk("rst_rspv",    {30'd0, rsp_valid},   32'd0);
    chk("rst_status",  {30'd0, rsp_status},  32'd0);
    chk("rst_rspbal",  {24'd0, rsp_balance}, 32'd0);
    chk("rst_busy",    {31'd0, busy},        32'd0);

    txn("dep30",   0, 2'b01, 8'd30,  2'b00, 8'd80,  0);
    txn("wdr81",   1, 2'b10, 8'd81,  2'b01, 8'd80,  0);
    txn("wdr80",   1, 2'b10, 8'd80,  2'b00, 8'd0,   0);
    txn("dep200",  0, 2'b01, 8'd200, 2'b00, 8'd200, 0);
    txn("dep56",   0, 2'b01, 8'd56,  2'b10, 8'd200, 0);
    txn("dep55",   0, 2'b01, 8'd55,  2'b00, 8'd255, 0);
    txn("badop",   1, 2'b11, 8'd99,  2'b11, 8'd255, 0);
    txn("tamper",  1, 2'b10, 8'd5,   2'b00, 8'd250, 1);
    txn("dep0",    0, 2'b01, 8'd0,   2'b00, 8'd250, 0);
    txn("wdr0",    1, 2'b10, 8'd0,   2'b00, 8'd250, 0);
    txn("query",   0, 2'b00, 8'd7,   2'b00, 8'd250, 0);
    txn("query1",  1, 2'b00, 8'd0,   2'b00, 8'd250, 0);

    // Both requesters hold queries; last served was requester 1
    req_op = 4'b0000;
    req_valid = 2'b11;
    ng = 0; both_ready = 0;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (req_ready == 2'b11) both_ready = 1;
      if (|req_ready && ng < 5) begin
        grants[ng] = req_ready[1] ? 1 : 0;
        gcyc[ng]   = c;
        ng++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("rr_never_both", {31'd0, both_ready}, 32'd0);
    chk("rr_count", ng, 5);
    if (ng == 5) begin
      chk("rr_g0", grants[0], 0);
      chk("rr_g1", grants[1], 1);
      chk("rr_g2", grants[2], 0);
      chk("rr_g3", grants[3], 1);
      chk("rr_sp1", gcyc[1] - gcyc[0], 3);
      chk("rr_sp2", gcyc[2] - gcyc[1], 3);
      chk("rr_sp3", gcyc[3] - gcyc[2], 3);
    end
    repeat (4) @(negedge clk);
    chk("rr_balance", {24'd0, balance}, 32'd250);

    // Abort: accept withdraw 10 from requester 0 (pointer now favours 1), reset in EXEC
    req_op[1:0] = 2'b10; req_amount[7:0] = 8'd10; req_valid = 2'b01;
    #1;
    chk("abort_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("abort_exec_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    saw_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) saw_rsp = 1;
    end
    chk("abort_no_rsp",  {31'd0, saw_rsp}, 32'd0);
    chk("abort_balance", {24'd0, balance}, 32'd50);
    chk("abort_busy",    {31'd0, busy},    32'd0);
    req_op = 4'b0000;
    req_valid = 2'b11;
    #1;
    chk("abort_first_grant", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/balance_ledger_arbiter.md
BALANCE_LEDGER_ARBITER -- requirements
Module: balance_ledger_arbiter

Interface
REQ-001 Parameter: INIT_BALANCE, default 8'd0, balance value loaded at reset.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid; bit 0 is the ATM FSM, bit 1 is the teller port.
REQ-005 req_op  input  4  2-bit opcode per requester, requester i at [2i+1:2i]: 00 query, 01 deposit, 10 withdraw, 11 reserved.
REQ-006 req_amount  input  16  8-bit unsigned amount per requester, requester i at [8i+7:8i].
REQ-007 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-008 rsp_valid  output  2  one-cycle response pulse to the requester whose transaction completed.
REQ-009 rsp_status  output  2  shared response status: 00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 BAD_OP.
REQ-010 rsp_balance  output  8  shared field: balance after the transaction; valid when any rsp_valid bit is high.
REQ-011 balance  output  8  current committed ledger balance, registered.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-014 FSM transitions SHALL be: IDLE->EXEC on handshake; EXEC->RESP always; RESP->IDLE always.
REQ-015 Handshake: a transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both high; a requester SHALL hold valid, op and amount stable until accepted.
REQ-016 req_ready SHALL be combinational: high only in IDLE, only for the granted requester, and only if that requester's req_valid is high.
REQ-017 Arbitration SHALL be round-robin: with a single requester valid, that requester wins; with both valid, the requester not served last wins; after reset, requester 0 wins a tie.
REQ-018 On acceptance, the grant index, op and amount SHALL be latched; later input changes have no effect on the transaction.
REQ-019 EXEC cycle SHALL compute the result and update balance at the EXEC->RESP edge.
REQ-020 In RESP, rsp_valid[grant] SHALL be high for exactly one cycle, with rsp_status and rsp_balance valid.
REQ-021 Latency from the acceptance edge to rsp_valid high is 2 cycles; a new acceptance is possible at the earliest 3 cycles after the previous one.
REQ-022 Query SHALL leave balance unchanged and return status OK.
REQ-023 Deposit SHALL compute a 9-bit sum; if the sum exceeds 255, status is OVERFLOW and balance is unchanged; otherwise balance equals the sum and status is OK.
REQ-024 Withdraw SHALL set status INSUFFICIENT and leave balance unchanged if amount is greater than balance; otherwise balance equals balance minus amount and status is OK.
REQ-025 A withdraw of amount equal to balance SHALL return OK with a resulting balance of 0.
REQ-026 An amount of 0 for deposit or withdraw SHALL return OK with balance unchanged.
REQ-027 Opcode 11 SHALL return BAD_OP with balance unchanged.
REQ-028 When rsp_valid is low, rsp_status and rsp_balance SHALL hold their last values.
REQ-029 busy SHALL be high in EXEC and RESP.
REQ-030 A request arriving while busy SHALL wait and SHALL NOT be dropped.
REQ-031 The round-robin pointer SHALL update only on acceptance.

Reset
REQ-032 rst SHALL force, on the next rising edge: state to IDLE, balance to INIT_BALANCE, rsp_valid to 00, rsp_status to 00, rsp_balance to 8'd0, round-robin pointer favouring requester 0.
REQ-033 Reset asserted in EXEC or RESP SHALL abort the transaction: no rsp_valid pulse, and balance equals INIT_BALANCE.
REQ-034 While rst is high, req_ready SHALL be 00.

Structure
REQ-035 Opcode encodings, status encodings and FSM state encodings SHALL reside in the shared package atm_pkg.
REQ-036 Arbitration SHALL be a sub-module rr_arbiter_2 with inputs req[1:0] and advance, and output one-hot gnt[1:0].
REQ-037 All arithmetic and the FSM SHALL remain in balance_ledger_arbiter.

Verification
REQ-038 Reset with INIT_BALANCE=50, then requester 0 deposits 30 -> rsp_valid[0] 2 cycles after acceptance, status OK, rsp_balance 80, balance 80.
REQ-039 balance=80, requester 1 withdraws 81 -> status INSUFFICIENT, balance 80; then withdraws 80 -> status OK, balance 0.
REQ-040 balance=200, deposit 56 -> status OVERFLOW, balance 200; then deposit 55 -> status OK, balance 255.
REQ-041 Both requesters hold query requests continuously -> grants alternate 0,1,0,1; acceptance spacing is 3 cycles; req_ready is never 11.
REQ-042 Accept a withdraw of 10, assert rst during EXEC -> no rsp_valid pulse, balance equals INIT_BALANCE, first grant after reset goes to requester 0.
REQ-043 Opcode 11 with amount 99 -> status BAD_OP and balance unchanged; requester changes its amount during EXEC -> result unaffected.
